bcd_timer_n: RTL
================

Name: bcd_timer_n

Overview:
- Parametrised N-digit BCD stopwatch/countdown timer with an integrated tick prescaler.
- Supports up/down count, programmable limit, load, pause/resume, and optional wrap.
- Single clock domain. Replaces the derived 1 Hz clock with a one-cycle tick enable.
- Feeds the seven-segment display mux and the lab FSMs that consume the done/expiry flag.

Parameters:
- DIGITS, 4, number of BCD digits (1..8); count width is 4*DIGITS.
- TICK_DIV, 100_000_000, clk cycles per count step (>=2); prescaler width = clog2(TICK_DIV).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  level-sampled command: begin or resume counting
- pause  in  1  level-sampled command: freeze count, keep value
- load  in  1  one-cycle strobe: cnt <= load_val, go IDLE
- dir  in  1  0 = count up toward limit, 1 = count down toward 0; sampled every tick
- wrap_en  in  1  1 = wrap at terminal value and keep running; 0 = stop in DONE
- load_val  in  4*DIGITS  BCD preload value, digit 0 = LSB nibble
- limit  in  4*DIGITS  BCD terminal value (up) / reload value (down)
- cnt  out  4*DIGITS  current BCD count
- running  out  1  high in RUN
- tick  out  1  one-cycle pulse on each count step
- done  out  1  sticky expiry flag (DONE state)
- wrap_pulse  out  1  one-cycle pulse on each wrap event

Behaviour:
- Reset (sync, active-high): cnt=0, prescaler=0, state=IDLE; running=0, tick=0, done=0, wrap_pulse=0.
- States: IDLE, RUN, PAUSE, DONE.
  - IDLE --start--> RUN.
  - RUN --pause--> PAUSE.
  - PAUSE --start & ~pause--> RUN.
  - RUN --terminal & ~wrap_en--> DONE.
  - DONE --start--> RUN, with cnt restarted: 0 if dir=0, limit if dir=1; done cleared.
  - Any state --load--> IDLE.
- Priority per cycle: rst > load > pause > start > tick.
- Prescaler:
  - Counts only in RUN; held at 0 in every other state.
  - At TICK_DIV-1 it returns to 0 and tick=1 for that cycle.
  - First tick occurs TICK_DIV cycles after entering RUN; resume from PAUSE restarts the full period.
- cnt update: registered on the clk edge where tick=1, so the new value is visible the cycle after the tick pulse.
- Up step:
  - Digit i increments; a digit at 9 goes to 0 and carries into digit i+1.
  - Terminal condition is cnt==limit at tick time. wrap_en=1 gives cnt<=0 and wrap_pulse=1. wrap_en=0 gives DONE with cnt held at limit.
  - If cnt>limit (after a load), counting continues and wraps modulo 10^DIGITS to 0 (no wrap_pulse) until limit is reached.
- Down step:
  - Digit i decrements; a digit at 0 goes to 9 and borrows from digit i+1.
  - Terminal condition is cnt==0 at tick time. wrap_en=1 gives cnt<=limit and wrap_pulse=1. wrap_en=0 gives DONE with cnt held at 0.
- Load:
  - Any nibble >9 in load_val is clamped to 9.
  - load clears done and the prescaler.
  - load and start in the same cycle: load wins; start is ignored that cycle.
- limit nibbles >9 are treated as 9.
- dir change mid-run takes effect at the next tick; no glitch on cnt.
- done=1 only in DONE; running=1 only in RUN; tick and wrap_pulse are never high outside RUN.
- rst asserted mid-run returns every output to its reset value on the next edge.

Decomposition:
- Shared package timer_pkg:
  - BCD_MAX=4'd9
  - state enum {IDLE, RUN, PAUSE, DONE}
  - function bcd_clamp(nibble)
- One sub-module, bcd_digit_cell.
  - Inputs: digit, inc, dec.
  - Outputs: next digit, carry_out, borrow_out, is_zero, is_nine.
  - Instantiated DIGITS times via generate; carry/borrow chained LSB to MSB.
- Prescaler, FSM and terminal compare live in bcd_timer_n.

Test Plan (DIGITS=2, TICK_DIV=4):
- Reset, load_val=00, limit=29, dir=0, wrap_en=0, start -> tick every 4 cycles; cnt 00,01,...,09,10,...,29; done=1 at 29, running=0, cnt holds 29.
- load_val=10, dir=1, wrap_en=1, limit=15, start -> cnt 10,09,...,00,15,14; wrap_pulse exactly once at 00->15; done stays 0.
- Up count to 05, assert pause 6 cycles, release, start -> cnt frozen at 05 with no tick; next tick 4 cycles after resume; cnt 06.
- load_val=0xA7 -> cnt=97 (clamped); load asserted with start in the same cycle -> state IDLE, no tick.
- In DONE, start with dir=1, limit=03 -> cnt=03, done=0, then 02,01,00 -> DONE.
- rst asserted mid-run at cnt=18 -> next cycle cnt=00, running=0, tick=0, done=0.

Source files
------------

// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the BCD stopwatch/countdown timer:
//   BCD_MAX    largest legal BCD digit value
//   state_e    timer control states
//   bcd_clamp  saturate a nibble into the legal BCD range 0..9
// -----------------------------------------------------------------------------
package timer_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Nibbles above 9 are not BCD; they saturate to 9.
    function automatic logic [3:0] bcd_clamp(input logic [3:0] nibble);
        if (nibble > BCD_MAX) begin
            return BCD_MAX;
        end else begin
            return nibble;
        end
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// -----------------------------------------------------------------------------
// bcd_digit_cell
// One BCD digit of the step datapath. Purely combinational: given the current
// digit and an increment or decrement request, produces the stepped digit and
// the carry/borrow into the next more significant digit.
// Ports:
//   digit_i    current BCD digit (0..9)
//   inc_i      increment request (carry in)
//   dec_i      decrement request (borrow in)
//   next_o     stepped digit
//   carry_o    digit wrapped 9 -> 0 while incrementing
//   borrow_o   digit wrapped 0 -> 9 while decrementing
//   is_zero_o  digit equals 0
//   is_nine_o  digit equals 9
// -----------------------------------------------------------------------------
module bcd_digit_cell
    import timer_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       inc_i,
    input  logic       dec_i,
    output logic [3:0] next_o,
    output logic       carry_o,
    output logic       borrow_o,
    output logic       is_zero_o,
    output logic       is_nine_o
);

    logic zero_s;
    logic nine_s;

    assign zero_s    = (digit_i == 4'd0);
    assign nine_s    = (digit_i == BCD_MAX);
    assign is_zero_o = zero_s;
    assign is_nine_o = nine_s;

    // Simultaneous inc and dec cancel out so the digit never glitches.
    assign carry_o  = inc_i & ~dec_i & nine_s;
    assign borrow_o = dec_i & ~inc_i & zero_s;

    // Next digit value for a single BCD step.
    always_comb begin
        next_o = digit_i;
        if (inc_i && !dec_i) begin
            next_o = nine_s ? 4'd0 : (digit_i + 4'd1);
        end else if (dec_i && !inc_i) begin
            next_o = zero_s ? BCD_MAX : (digit_i - 4'd1);
        end else begin
            next_o = digit_i;
        end
    end

endmodule

// File: rtl/bcd_timer_n.sv
// -----------------------------------------------------------------------------
// bcd_timer_n
// N-digit BCD stopwatch / countdown timer with built-in tick prescaler.
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset
//   start       begin / resume counting (level)
//   pause       freeze count (level)
//   load        one-cycle strobe: cnt <= clamped load_val, go IDLE
//   dir         0 = count up toward limit, 1 = count down toward 0
//   wrap_en     1 = wrap at terminal value, 0 = stop in DONE
//   load_val    BCD preload value (digit 0 in the LSB nibble)
//   limit       BCD terminal value (up) / reload value (down)
//   cnt         current BCD count
//   running     high in RUN
//   tick        one-cycle pulse on each count step
//   done        sticky expiry flag, high in DONE
//   wrap_pulse  one-cycle pulse on each wrap event
// -----------------------------------------------------------------------------
module bcd_timer_n
    import timer_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 100_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  load,
    input  logic                  dir,
    input  logic                  wrap_en,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic [4*DIGITS-1:0]   limit,
    output logic [4*DIGITS-1:0]   cnt,
    output logic                  running,
    output logic                  tick,
    output logic                  done,
    output logic                  wrap_pulse
);

    localparam int            PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    state_e                state_q, state_d;
    logic [4*DIGITS-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]         presc_q, presc_d;

    logic [4*DIGITS-1:0]   load_c_s;
    logic [4*DIGITS-1:0]   limit_c_s;
    logic [4*DIGITS-1:0]   step_s;
    logic [DIGITS:0]       inc_s;
    logic [DIGITS:0]       dec_s;
    logic [DIGITS-1:0]     zero_s;
    logic [DIGITS-1:0]     nine_s;
    logic                  term_s;
    logic                  tick_s;
    logic                  wrap_s;
    logic                  chain_unused_s;

    // Saturate non-BCD nibbles of the preload and limit values.
    always_comb begin
        load_c_s  = '0;
        limit_c_s = '0;
        for (int i = 0; i < DIGITS; i++) begin
            load_c_s[4*i +: 4]  = bcd_clamp(load_val[4*i +: 4]);
            limit_c_s[4*i +: 4] = bcd_clamp(limit[4*i +: 4]);
        end
    end

    // The chain always computes the next step in the current direction;
    // it is only committed to cnt on a tick.
    assign inc_s[0] = ~dir;
    assign dec_s[0] = dir;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_digit
            bcd_digit_cell u_cell (
                .digit_i   (cnt_q[4*g +: 4]),
                .inc_i     (inc_s[g]),
                .dec_i     (dec_s[g]),
                .next_o    (step_s[4*g +: 4]),
                .carry_o   (inc_s[g+1]),
                .borrow_o  (dec_s[g+1]),
                .is_zero_o (zero_s[g]),
                .is_nine_o (nine_s[g])
            );
        end
    endgenerate

    // Overflow out of the MSB is the natural modulo-10^DIGITS rollover,
    // so the chain ends and the nine flags carry no further meaning here.
    assign chain_unused_s = ^{inc_s[DIGITS], dec_s[DIGITS], nine_s};

    // Terminal value depends on the direction sampled at tick time.
    assign term_s = dir ? (&zero_s) : (cnt_q == limit_c_s);

    // Next-state, prescaler and count logic; priority rst > load > pause > start > tick.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        presc_d = presc_q;
        tick_s  = 1'b0;
        wrap_s  = 1'b0;
        if (rst) begin
            state_d = IDLE;
            cnt_d   = '0;
            presc_d = '0;
        end else if (load) begin
            state_d = IDLE;
            cnt_d   = load_c_s;
            presc_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    presc_d = '0;
                    if (start && !pause) begin
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_d = PAUSE;
                        presc_d = '0;
                    end else if (presc_q == PRESC_LAST) begin
                        presc_d = '0;
                        tick_s  = 1'b1;
                        if (term_s) begin
                            if (wrap_en) begin
                                cnt_d  = dir ? limit_c_s : '0;
                                wrap_s = 1'b1;
                            end else begin
                                state_d = DONE;
                            end
                        end else begin
                            cnt_d = step_s;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                PAUSE: begin
                    presc_d = '0;
                    if (start && !pause) begin
                        state_d = RUN;
                    end else begin
                        state_d = PAUSE;
                    end
                end
                DONE: begin
                    presc_d = '0;
                    if (start && !pause) begin
                        state_d = RUN;
                        cnt_d   = dir ? limit_c_s : '0;
                    end else begin
                        state_d = DONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    presc_d = '0;
                end
            endcase
        end
    end

    // State, count and prescaler registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            presc_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            presc_q <= presc_d;
        end
    end

    assign cnt        = cnt_q;
    assign running    = (state_q == RUN);
    assign done       = (state_q == DONE);
    assign tick       = tick_s;
    assign wrap_pulse = wrap_s;

endmodule
